// File: rtl/seg_pkg.sv
// Shared types and constants for the 16-digit 7-segment scan controller.
package seg_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NDIG   = 16;

  // Register word addresses
  localparam logic [ADDR_W-1:0] ADDR_DIGLO  = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIGHI  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_MASK   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_DP     = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 3'd5;

  // Control register reset values
  localparam logic        CTRL_EN_RST     = 1'b1;
  localparam logic        CTRL_BLINK_RST  = 1'b0;
  localparam logic [3:0]  CTRL_BRIGHT_RST = 4'hF;
  localparam logic [31:0] MASK_RST        = 32'h0000_FFFF;

  // Active-low {dp, g..a} codes for hex digits 0..F
  localparam logic [7:0] SEG_HEX [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {
    BUS_IDLE,
    BUS_RESP
  } bus_state_e;

  // Layout of the read-only STATUS word
  typedef struct packed {
    logic [15:0] frame;
    logic [10:0] rsvd;
    logic        blink_ph;
    logic [3:0]  digit;
  } status_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// MMIO request/response bus between the CPU and the scan controller.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/seg_hex_dec.sv
// Hex nibble to active-low g..a segment pattern.
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n_c
);

  // Table lookup; the DP bit of the table entry is dropped here
  always_comb begin
    seg_n_c = SEG_HEX[hex][6:0];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Bus-programmable time-multiplexed scan controller for a 16-digit 7-segment display.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 10000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_scan_ctrl_if.slave  bus,
  output logic [NDIG-1:0] seg_sel_n,
  output logic [7:0]      seg
);

  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned FRM_W = 16;
  localparam int unsigned PWM_W = 4;

  bus_state_e        state;

  logic [63:0]       dig;
  logic              ctrl_en;
  logic              ctrl_blink;
  logic [3:0]        bright;
  logic [31:0]       mask;
  logic [NDIG-1:0]   dp;

  logic [PRE_W-1:0]  pre_cnt;
  logic [IDX_W-1:0]  idx;
  logic [FRM_W-1:0]  frame_cnt;
  logic [BLK_W-1:0]  blink_cnt;
  logic              blink_ph;
  logic [PWM_W-1:0]  pwm_cnt;

  logic              accept_c;
  logic              scan_tick_c;
  logic              frame_wrap_c;
  logic              pwm_on_c;
  logic              blank_c;
  logic [3:0]        cur_hex_c;
  logic [6:0]        hex_seg_c;
  status_t           status_c;
  logic [DATA_W-1:0] rd_data_c;

  assign accept_c     = (state == BUS_IDLE) && bus.bus_valid;
  assign scan_tick_c  = ctrl_en && (pre_cnt == PRE_W'(SCAN_DIV - 1));
  assign frame_wrap_c = scan_tick_c && (idx == IDX_W'(NDIG - 1));
  assign pwm_on_c     = (pwm_cnt <= bright);
  assign cur_hex_c    = dig[{idx, 2'b00} +: 4];

  // Blank when disabled, digit masked off, in the PWM off-time, or in the blink-off phase
  assign blank_c = !ctrl_en || !mask[idx] || !pwm_on_c ||
                   (ctrl_blink && mask[{1'b1, idx}] && blink_ph);

  seg_hex_dec u_hex_dec (
    .hex     (cur_hex_c),
    .seg_n_c (hex_seg_c)
  );

  // Live scan status as seen by a STATUS read
  always_comb begin
    status_c          = '0;
    status_c.frame    = frame_cnt;
    status_c.blink_ph = blink_ph;
    status_c.digit    = idx;
  end

  // Read data mux; unmapped words read as zero
  always_comb begin
    rd_data_c = '0;
    case (bus.bus_addr)
      ADDR_DIGLO:  rd_data_c = dig[31:0];
      ADDR_DIGHI:  rd_data_c = dig[63:32];
      ADDR_CTRL:   rd_data_c = {24'h0, bright, 2'b00, ctrl_blink, ctrl_en};
      ADDR_MASK:   rd_data_c = mask;
      ADDR_DP:     rd_data_c = {16'h0, dp};
      ADDR_STATUS: rd_data_c = status_c;
      default:     rd_data_c = '0;
    endcase
  end

  // Bus FSM: accept in IDLE, answer with a one-cycle response strobe in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BUS_IDLE;
      bus.bus_ready  <= 1'b1;
      bus.bus_rvalid <= 1'b0;
      bus.bus_rdata  <= '0;
    end else begin
      case (state)
        BUS_IDLE: begin
          if (bus.bus_valid) begin
            state          <= BUS_RESP;
            bus.bus_ready  <= 1'b0;
            bus.bus_rvalid <= 1'b1;
            bus.bus_rdata  <= bus.bus_we ? '0 : rd_data_c;
          end
        end
        default: begin
          state          <= BUS_IDLE;
          bus.bus_ready  <= 1'b1;
          bus.bus_rvalid <= 1'b0;
          bus.bus_rdata  <= '0;
        end
      endcase
    end
  end

  // Register file; writes land at the accept edge, STATUS and spare words ignore writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig        <= '0;
      ctrl_en    <= CTRL_EN_RST;
      ctrl_blink <= CTRL_BLINK_RST;
      bright     <= CTRL_BRIGHT_RST;
      mask       <= MASK_RST;
      dp         <= '0;
    end else if (accept_c && bus.bus_we) begin
      case (bus.bus_addr)
        ADDR_DIGLO: dig[31:0]  <= bus.bus_wdata;
        ADDR_DIGHI: dig[63:32] <= bus.bus_wdata;
        ADDR_CTRL: begin
          ctrl_en    <= bus.bus_wdata[0];
          ctrl_blink <= bus.bus_wdata[1];
          bright     <= bus.bus_wdata[7:4];
        end
        ADDR_MASK:  mask <= bus.bus_wdata;
        ADDR_DP:    dp   <= bus.bus_wdata[15:0];
        default: ;
      endcase
    end
  end

  // Prescaler, digit index, frame and blink counters; held at the origin while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt   <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (!ctrl_en) begin
      pre_cnt   <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else begin
      if (scan_tick_c) begin
        pre_cnt <= '0;
        idx     <= idx + IDX_W'(1);
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
      if (frame_wrap_c) begin
        frame_cnt <= frame_cnt + FRM_W'(1);
        if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end
    end
  end

  // Free-running brightness PWM phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  // Registered display pins, one cycle behind the scan state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sel_n <= '1;
      seg       <= '1;
    end else if (blank_c) begin
      seg_sel_n <= '1;
      seg       <= '1;
    end else begin
      seg_sel_n <= ~(NDIG'(1) << idx);
      seg       <= {~dp[idx], hex_seg_c};
    end
  end

endmodule
